// File: rtl/invader_pkg.sv
// Shared invader types and row geometry, used by both this controller and the display block.
package invader_pkg;
  import vga_pkg::*;

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_EVAL = 3'd1,
    S_HORZ = 3'd2,
    S_DOWN = 3'd3,
    S_OVER = 3'd4
  } state_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  // Gap between sprites so the row fills the screen width minus the offset.
  function automatic int calc_spacing(input int offset, input int num, input int width);
    return ((HOR_PIXELS - offset) - num * width) / (num - 1);
  endfunction

  function automatic int calc_pitch(input int offset, input int num, input int width);
    return width + calc_spacing(offset, num, width);
  endfunction
endpackage

// File: rtl/vga_pkg.sv
// XGA 1024x768 @ 60 Hz timing constants shared by the video path.
package vga_pkg;
  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
endpackage

// File: rtl/invader_scan.sv
// Combinational scan of the alive mask: highest alive index and alive count.
module invader_scan #(
  parameter int NUM_INVADERS = 10
) (
  input  logic [NUM_INVADERS-1:0]           enable,
  output logic [$clog2(NUM_INVADERS)-1:0]   hi_idx,
  output logic [$clog2(NUM_INVADERS+1)-1:0] pop
);
  localparam int IW = $clog2(NUM_INVADERS);
  localparam int PW = $clog2(NUM_INVADERS + 1);

  always_comb begin
    hi_idx = '0;
    pop    = '0;
    for (int i = 0; i < NUM_INVADERS; i++) begin
      if (enable[i]) begin
        hi_idx = IW'(i);
        pop    = pop + PW'(1);
      end
    end
  end
endmodule

// File: rtl/invader_formation_ctl.sv
// Formation motion controller: marches the invader row, drops at screen edges,
// clears invaders on hits and flags game over.
module invader_formation_ctl
  import invader_pkg::*;
#(
  parameter int X_INIT         = 50,
  parameter int Y_INIT         = 100,
  parameter int INVADER_WIDTH  = 64,
  parameter int INVADER_HEIGHT = 48,
  parameter int NUM_INVADERS   = 10,
  parameter int OFFSET         = 100,
  parameter int STEP_X         = 8,
  parameter int STEP_Y         = 16,
  parameter int BASE_FRAMES    = 2,
  parameter int BOTTOM_Y       = 700
) (
  input  logic                            clk65MHz,
  input  logic                            rst,
  input  logic                            frame_tick,
  input  logic                            restart,
  input  logic                            hit_valid,
  input  logic [$clog2(NUM_INVADERS)-1:0] hit_index,
  output logic [9:0]                      xpos,
  output logic [9:0]                      ypos,
  output logic [NUM_INVADERS-1:0]         invader_enable,
  output logic                            score_pulse,
  output logic                            all_destroyed,
  output logic                            reached_bottom,
  output state_e                          dbg_state,
  output dir_e                            dbg_dir
);
  localparam int IW = $clog2(NUM_INVADERS);
  localparam int PW = $clog2(NUM_INVADERS + 1);

  // Edge arithmetic is carried at 12 bits so nothing wraps before the compare.
  localparam logic [11:0] PITCH12   = 12'(calc_pitch(OFFSET, NUM_INVADERS, INVADER_WIDTH));
  localparam logic [11:0] X_INIT12  = 12'(X_INIT);
  localparam logic [11:0] Y_INIT12  = 12'(Y_INIT);
  localparam logic [11:0] WIDTH12   = 12'(INVADER_WIDTH);
  localparam logic [11:0] HEIGHT12  = 12'(INVADER_HEIGHT);
  localparam logic [11:0] STEP_X12  = 12'(STEP_X);
  localparam logic [11:0] HOR12     = 12'(vga_pkg::HOR_PIXELS);
  localparam logic [11:0] BOTTOM12  = 12'(BOTTOM_Y);
  localparam logic [9:0]  STEP_X10  = 10'(STEP_X);
  localparam logic [9:0]  STEP_Y10  = 10'(STEP_Y);
  localparam logic [6:0]  BASE7     = 7'(BASE_FRAMES);

  state_e                  state_q, state_d;
  dir_e                    dir_q, dir_d;
  logic [9:0]              xpos_q, xpos_d;
  logic [9:0]              ypos_q, ypos_d;
  logic [NUM_INVADERS-1:0] enable_q, enable_d;
  logic [5:0]              cnt_q, cnt_d;
  logic                    score_q, score_d;
  logic                    all_destroyed_q, all_destroyed_d;
  logic                    reached_bottom_q, reached_bottom_d;

  logic [IW-1:0]           hi_idx;
  logic [PW-1:0]           pop;
  logic                    hit_in_range;
  logic                    hit_ok;
  logic [6:0]              period_m1;
  logic                    period_done;
  logic [11:0]             right_edge;
  logic [9:0]              ypos_drop;
  logic [11:0]             bottom_edge;

  invader_scan #(
    .NUM_INVADERS (NUM_INVADERS)
  ) u_scan (
    .enable (enable_q),
    .hi_idx (hi_idx),
    .pop    (pop)
  );

  always_comb begin
    hit_in_range = ({1'b0, hit_index} < (IW + 1)'(NUM_INVADERS));
    hit_ok       = hit_valid && hit_in_range && (state_q != S_OVER) && enable_q[hit_index];
    // Period uses the mask as it stands this cycle, before any same-cycle hit lands.
    period_m1    = BASE7 + 7'(pop) - 7'd1;
    period_done  = ({1'b0, cnt_q} >= period_m1);
    right_edge   = X_INIT12 + 12'(xpos_q) + 12'(hi_idx) * PITCH12 + WIDTH12 + STEP_X12;
    ypos_drop    = ypos_q + STEP_Y10;
    bottom_edge  = Y_INIT12 + 12'(ypos_drop) + HEIGHT12;
  end

  always_comb begin
    state_d          = state_q;
    dir_d            = dir_q;
    xpos_d           = xpos_q;
    ypos_d           = ypos_q;
    enable_d         = enable_q;
    cnt_d            = cnt_q;
    score_d          = 1'b0;
    all_destroyed_d  = all_destroyed_q;
    reached_bottom_d = reached_bottom_q;

    if (hit_ok) begin
      enable_d[hit_index] = 1'b0;
      score_d             = 1'b1;
    end

    case (state_q)
      S_WAIT: begin
        if (enable_q == '0) begin
          all_destroyed_d = 1'b1;
          state_d         = S_OVER;
        end else if (frame_tick) begin
          if (period_done) begin
            cnt_d   = '0;
            state_d = S_EVAL;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_EVAL: begin
        // The left edge is the formation origin; dead leading invaders do not extend it.
        if (dir_q == DIR_RIGHT) begin
          state_d = (right_edge > HOR12) ? S_DOWN : S_HORZ;
        end else begin
          state_d = (12'(xpos_q) < STEP_X12) ? S_DOWN : S_HORZ;
        end
      end
      S_HORZ: begin
        xpos_d  = (dir_q == DIR_RIGHT) ? (xpos_q + STEP_X10) : (xpos_q - STEP_X10);
        state_d = S_WAIT;
      end
      S_DOWN: begin
        ypos_d = ypos_drop;
        dir_d  = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
        if (bottom_edge >= BOTTOM12) begin
          reached_bottom_d = 1'b1;
          state_d          = S_OVER;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk65MHz) begin
    if (rst || restart) begin
      state_q          <= S_WAIT;
      dir_q            <= DIR_RIGHT;
      xpos_q           <= '0;
      ypos_q           <= '0;
      enable_q         <= '1;
      cnt_q            <= '0;
      score_q          <= 1'b0;
      all_destroyed_q  <= 1'b0;
      reached_bottom_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      dir_q            <= dir_d;
      xpos_q           <= xpos_d;
      ypos_q           <= ypos_d;
      enable_q         <= enable_d;
      cnt_q            <= cnt_d;
      score_q          <= score_d;
      all_destroyed_q  <= all_destroyed_d;
      reached_bottom_q <= reached_bottom_d;
    end
  end

  assign xpos           = xpos_q;
  assign ypos           = ypos_q;
  assign invader_enable = enable_q;
  assign score_pulse    = score_q;
  assign all_destroyed  = all_destroyed_q;
  assign reached_bottom = reached_bottom_q;
  assign dbg_state      = state_q;
  assign dbg_dir        = dir_q;
endmodule
